laser_cover_eval: RTL and testbench

LASER_COVER_EVAL -- requirements
Module: laser_cover_eval

---
 rtl/laser_pkg.sv | 18 +
 rtl/laser_dist_cmp.sv | 34 +++
 rtl/laser_cover_eval.sv | 104 ++++++++++
 tb/tb_laser_cover_eval.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and defaults for the two-circle laser coverage evaluator.
package laser_pkg;
    localparam int NPTS = 40;
    localparam int R2   = 16;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [1:0] {LOAD, READY, EVAL, REPORT} state_t;

    function automatic coord_t absdiff(input coord_t a, input coord_t b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/laser_dist_cmp.sv
// Combinational coverage test: is point (px,py) within R2 of either centre.
module laser_dist_cmp #(
    parameter int R2 = laser_pkg::R2
) (
    input  logic [3:0] c1x,
    input  logic [3:0] c1y,
    input  logic [3:0] c2x,
    input  logic [3:0] c2y,
    input  logic [3:0] px,
    input  logic [3:0] py,
    output logic       covered
);
    import laser_pkg::*;

    coord_t     dx1, dy1, dx2, dy2;
    logic [7:0] sx1, sy1, sx2, sy2;
    logic [8:0] d1, d2;

    assign dx1 = absdiff(c1x, px);
    assign dy1 = absdiff(c1y, py);
    assign dx2 = absdiff(c2x, px);
    assign dy2 = absdiff(c2y, py);

    // 4-bit magnitudes square into 8 bits and sum into 9, so nothing wraps.
    assign sx1 = {4'b0, dx1} * {4'b0, dx1};
    assign sy1 = {4'b0, dy1} * {4'b0, dy1};
    assign sx2 = {4'b0, dx2} * {4'b0, dx2};
    assign sy2 = {4'b0, dy2} * {4'b0, dy2};

    assign d1 = {1'b0, sx1} + {1'b0, sy1};
    assign d2 = {1'b0, sx2} + {1'b0, sy2};

    assign covered = (d1 <= 9'(R2)) || (d2 <= 9'(R2));
endmodule

// File: rtl/laser_cover_eval.sv
// Point buffer plus evaluation FSM: counts stored points covered by two circles.
module laser_cover_eval #(
    parameter int NPTS = laser_pkg::NPTS,
    parameter int R2   = laser_pkg::R2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic       LOAD_DONE,
    input  logic       START,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       BUSY,
    output logic [5:0] CNT,
    output logic       CNT_VALID
);
    import laser_pkg::*;

    localparam int            IW   = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NPTS - 1);

    state_t        state;
    logic [IW-1:0] wr_ptr, idx;
    point_t        buf_q [NPTS];
    point_t        c1, c2, cur;
    logic [5:0]    acc;
    logic          covered;

    // Buffer has no reset; a fresh load overwrites every entry.
    always_ff @(posedge CLK) begin
        if (!RST && state == LOAD && IN_VALID)
            buf_q[wr_ptr] <= {X, Y};
    end

    assign cur = buf_q[idx];

    laser_dist_cmp #(.R2(R2)) u_cmp (
        .c1x     (c1.x),
        .c1y     (c1.y),
        .c2x     (c2.x),
        .c2y     (c2.y),
        .px      (cur.x),
        .py      (cur.y),
        .covered (covered)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            idx       <= '0;
            acc       <= '0;
            c1        <= '0;
            c2        <= '0;
            LOAD_DONE <= 1'b0;
            BUSY      <= 1'b0;
            CNT       <= '0;
            CNT_VALID <= 1'b0;
        end else begin
            CNT_VALID <= 1'b0;
            case (state)
                LOAD: begin
                    if (IN_VALID) begin
                        if (wr_ptr == LAST) begin
                            wr_ptr    <= '0;
                            LOAD_DONE <= 1'b1;
                            state     <= READY;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (START) begin
                        c1    <= {C1X, C1Y};
                        c2    <= {C2X, C2Y};
                        idx   <= '0;
                        acc   <= '0;
                        BUSY  <= 1'b1;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    acc <= acc + 6'(covered);
                    if (idx == LAST) begin
                        idx       <= '0;
                        CNT       <= acc + 6'(covered);
                        CNT_VALID <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= REPORT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                REPORT: state <= READY;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_cover_eval.sv
// Randomized bench for laser_cover_eval against a cycle-level behavioural model.
module tb_laser_cover_eval;
    localparam int NPTS = 40;
    localparam int R2   = 16;

    logic       CLK = 1'b0;
    logic       RST, IN_VALID, START, LOAD_DONE, BUSY, CNT_VALID;
    logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
    logic [5:0] CNT;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 CLK = ~CLK;

    laser_cover_eval #(.NPTS(NPTS), .R2(R2)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y),
        .LOAD_DONE(LOAD_DONE), .START(START),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .BUSY(BUSY), .CNT(CNT), .CNT_VALID(CNT_VALID)
    );

    // Model: points loaded so far, cycles left in an evaluation, result.
    logic [7:0] m_pts [NPTS];
    int m_loaded = 0, m_left = 0, m_res = 0, m_cnt = 0;
    bit m_vld = 0;

    function automatic int count_cov(input int ax, input int ay, input int bx, input int by);
        int n, px, py;
        n = 0;
        for (int i = 0; i < NPTS; i++) begin
            px = int'(m_pts[i][7:4]);
            py = int'(m_pts[i][3:0]);
            if ((ax-px)*(ax-px) + (ay-py)*(ay-py) <= R2 ||
                (bx-px)*(bx-px) + (by-py)*(by-py) <= R2)
                n++;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_loaded <= 0;
            m_left   <= 0;
            m_vld    <= 0;
            m_cnt    <= 0;
        end else begin
            m_vld <= 0;
            if (m_loaded < NPTS && IN_VALID) begin
                m_pts[m_loaded] <= {X, Y};
                m_loaded <= m_loaded + 1;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_vld <= 1;
                    m_cnt <= m_res;
                end
            end else if (m_loaded == NPTS && !m_vld && START) begin
                m_left <= NPTS;
                m_res  <= count_cov(int'(C1X), int'(C1Y), int'(C2X), int'(C2Y));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("load_done", int'(LOAD_DONE), int'(m_loaded == NPTS));
            check("busy", int'(BUSY), int'(m_left != 0));
            check("cnt_valid", int'(CNT_VALID), int'(m_vld));
            check("cnt", int'(CNT), m_cnt);
        end
    end

    task automatic do_reset(input int n);
        RST = 1;
        repeat (n) @(negedge CLK);
        RST = 0;
    endtask

    // mode: 0=(8,8) 1=(0,0) 2=(4,0)/(4,1) split 3=(2,2) 4=random
    task automatic load_pattern(input int mode, input bit start_in_load);
        for (int i = 0; i < NPTS; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                IN_VALID = 0; X = 4'($urandom); Y = 4'($urandom);
                @(negedge CLK);
            end
            if (start_in_load && i == 5) begin
                IN_VALID = 0; START = 1; C1X = 8; C1Y = 8; C2X = 0; C2Y = 0;
                @(negedge CLK);
                START = 0;
            end
            IN_VALID = 1;
            case (mode)
                0: begin X = 8; Y = 8; end
                1: begin X = 0; Y = 0; end
                2: begin X = 4; Y = (i < 20) ? 4'd0 : 4'd1; end
                3: begin X = 2; Y = 2; end
                default: begin X = 4'($urandom); Y = 4'($urandom); end
            endcase
            @(negedge CLK);
        end
        IN_VALID = 0;
        check("load_done_lit", int'(LOAD_DONE), 1);
    endtask

    task automatic run_eval(input int ax, input int ay, input int bx, input int by,
                            input int exp, input bit lit, input int inject, input string name);
        int k;
        bit got;
        if (lit) check({name, "_model"}, count_cov(ax, ay, bx, by), exp);
        START = 1; C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by);
        @(negedge CLK);
        START = 0;
        k = 0; got = 0;
        while (k < 60 && !got) begin
            if (CNT_VALID) got = 1;
            else begin
                C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
                IN_VALID = 1'($urandom); X = 4'($urandom); Y = 4'($urandom);
                if (k == inject) START = 1;
                @(negedge CLK);
                START = 0;
                k++;
            end
        end
        IN_VALID = 0;
        check({name, "_seen"}, int'(got), 1);
        if (got) begin
            check({name, "_latency"}, k + 1, NPTS + 1);
            check({name, "_cnt"}, int'(CNT), exp);
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int pulses, ax, ay, bx, by;
        RST = 1; IN_VALID = 0; START = 0; X = 0; Y = 0;
        C1X = 0; C1Y = 0; C2X = 0; C2Y = 0;
        @(negedge CLK);
        chk_en = 1;
        @(negedge CLK);
        check("rst_load_done", int'(LOAD_DONE), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_cnt_valid", int'(CNT_VALID), 0);
        check("rst_cnt", int'(CNT), 0);
        RST = 0;

        // all at (8,8), START during load ignored, START mid-EVAL ignored, repeat reuses buffer
        load_pattern(0, 1);
        run_eval(8, 8, 0, 0, 40, 1, 10, "full");
        run_eval(8, 8, 0, 0, 40, 1, -1, "full_again");

        do_reset(2);
        load_pattern(1, 0);
        run_eval(15, 15, 15, 15, 0, 1, -1, "none");

        do_reset(2);
        load_pattern(2, 0);
        run_eval(0, 0, 15, 15, 20, 1, -1, "boundary");

        do_reset(2);
        load_pattern(3, 0);
        run_eval(0, 0, 4, 4, 40, 1, -1, "overlap");

        // reset on the 20th EVAL edge aborts the evaluation
        do_reset(2);
        load_pattern(4, 0);
        START = 1; C1X = 7; C1Y = 7; C2X = 3; C2Y = 12;
        @(negedge CLK);
        START = 0;
        repeat (19) @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        check("abort_busy", int'(BUSY), 0);
        check("abort_load_done", int'(LOAD_DONE), 0);
        check("abort_cnt_valid", int'(CNT_VALID), 0);
        @(negedge CLK);
        RST = 0;
        pulses = 0;
        repeat (50) begin
            @(negedge CLK);
            if (CNT_VALID) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        load_pattern(4, 0);
        run_eval(7, 7, 3, 12, count_cov(7, 7, 3, 12), 0, -1, "post_abort");

        for (int r = 0; r < 3; r++) begin
            do_reset(1);
            load_pattern(4, 0);
            for (int e = 0; e < 4; e++) begin
                ax = int'($urandom_range(0, 15)); ay = int'($urandom_range(0, 15));
                bx = int'($urandom_range(0, 15)); by = int'($urandom_range(0, 15));
                run_eval(ax, ay, bx, by, count_cov(ax, ay, bx, by), 0, (e == 1) ? 25 : -1, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
